// File: rtl/xlnx_startup_pkg.sv
// Shared state encodings and helpers for the host-link
// bring-up sequencer.
package xlnx_startup_pkg;

   typedef enum logic [3:0] {
      ST_DETECT    = 4'd0,
      ST_CLK_EN    = 4'd1,
      ST_PHY_REL   = 4'd2,
      ST_MMCM_RST  = 4'd3,
      ST_MMCM_REL  = 4'd4,
      ST_WAIT_LOCK = 4'd5,
      ST_LOGIC_H   = 4'd6,
      ST_LOGIC_L   = 4'd7,
      ST_DONE      = 4'd8,
      ST_NEXT      = 4'd9,
      ST_FAIL      = 4'd10
   } st_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/xlnx_startup_step_cnt.sv
// Step/detect dwell counter with registered clear,
// plus a lock-loss run detector.
module xlnx_startup_step_cnt
   import xlnx_startup_pkg::*;
#(
   parameter int STEP_BITS   = 8,
   parameter int DETECT_BITS = 28
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic sup_en,
   input  logic lock_s,
   output logic step_wrap,
   output logic det_wrap,
   output logic loss
);

   localparam int CW = (DETECT_BITS > STEP_BITS) ?
                       DETECT_BITS : STEP_BITS;

   logic [CW-1:0]        cnt_q;
   logic [CW-1:0]        cnt;
   logic [STEP_BITS-1:0] run_q;

   // clr is raised in the first cycle of a new state,
   // so the effective count reads zero on entry
   assign cnt       = clr ? '0 : cnt_q;
   assign step_wrap = &cnt[STEP_BITS-1:0];
   assign det_wrap  = &cnt[DETECT_BITS-1:0];
   assign loss      = sup_en & ~lock_s & (&run_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         run_q <= '0;
      end else begin
         cnt_q <= cnt + 1'b1;
         if (!sup_en || lock_s)
            run_q <= '0;
         else
            run_q <= run_q + 1'b1;
      end
   end

endmodule

// File: rtl/xlnx_startup_seq.sv
// Multi-mode clock/PHY/MMCM bring-up sequencer with
// bounded lock retries and lock-loss supervision.
module xlnx_startup_seq
   import xlnx_startup_pkg::*;
#(
   parameter int                NMODES       = 2,
   parameter logic [NMODES-1:0] PASSIVE_MASK = 2'b01,
   parameter bit                FORCE_EN     = 1'b0,
   parameter int                FORCE_IDX    = 0,
   parameter int                DETECT_BITS  = 28,
   parameter int                STEP_BITS    = 8,
   parameter int                LOCK_TRIES   = 4,
   parameter int                MAX_RETRY    = 3,
   parameter bit                RELOCK_EN    = 1'b1
) (
   input  logic              cfg_mclk,
   input  logic              cfg_rst_n,
   input  logic [NMODES-1:0] clk_ready,
   input  logic              mmcm_lock,
   output logic [NMODES-1:0] mode_sel,
   output logic [1:0]        mode_idx,
   output logic              clk_en,
   output logic              mmcm_rst_n,
   output logic              phy_nrst,
   output logic              logic_reset,
   output logic              user_reset,
   output logic              done,
   output logic              fail,
   output logic [1:0]        retry_cnt,
   output logic [3:0]        debug_state
);

   localparam int TW0 = clog2(LOCK_TRIES);
   localparam int TW  = (TW0 < 1) ? 1 : TW0;

   localparam logic [3:0]    PMASK    = 4'(PASSIVE_MASK);
   localparam logic [1:0]    INIT_IDX =
      FORCE_EN ? 2'(FORCE_IDX) : 2'd0;
   localparam logic [1:0]    LAST_IDX = 2'(NMODES - 1);
   localparam logic [1:0]    MAXR     = 2'(MAX_RETRY);
   localparam logic [TW-1:0] TRY_LAST = TW'(LOCK_TRIES - 1);
   localparam st_e           INIT_ST  =
      PMASK[INIT_IDX] ? ST_DETECT : ST_CLK_EN;

   st_e           state;
   logic [1:0]    lock_ff;
   logic          lock_s;
   logic          cnt_clr;
   logic [TW-1:0] tries;
   logic          step_wrap;
   logic          det_wrap;
   logic          loss;
   logic [3:0]    rdy;
   logic [3:0]    sel4;
   logic [1:0]    nxt_idx;

   assign lock_s      = lock_ff[1];
   assign rdy         = 4'(clk_ready);
   assign sel4        = 4'b0001 << mode_idx;
   assign mode_sel    = sel4[NMODES-1:0];
   assign nxt_idx     = mode_idx + 2'd1;
   assign debug_state = state;

   always_ff @(posedge cfg_mclk or negedge cfg_rst_n) begin
      if (!cfg_rst_n)
         lock_ff <= 2'b00;
      else
         lock_ff <= {lock_ff[0], mmcm_lock};
   end

   xlnx_startup_step_cnt #(
      .STEP_BITS   (STEP_BITS),
      .DETECT_BITS (DETECT_BITS)
   ) u_step_cnt (
      .clk       (cfg_mclk),
      .rst_n     (cfg_rst_n),
      .clr       (cnt_clr),
      .sup_en    (state == ST_DONE),
      .lock_s    (lock_s),
      .step_wrap (step_wrap),
      .det_wrap  (det_wrap),
      .loss      (loss)
   );

   always_ff @(posedge cfg_mclk or negedge cfg_rst_n) begin
      if (!cfg_rst_n) begin
         state       <= INIT_ST;
         mode_idx    <= INIT_IDX;
         cnt_clr     <= 1'b1;
         tries       <= '0;
         clk_en      <= 1'b0;
         mmcm_rst_n  <= 1'b1;
         phy_nrst    <= 1'b0;
         logic_reset <= 1'b1;
         user_reset  <= 1'b1;
         done        <= 1'b0;
         fail        <= 1'b0;
         retry_cnt   <= '0;
      end else begin
         cnt_clr <= 1'b0;
         unique case (state)
            ST_DETECT: begin
               if (lock_s) begin
                  state      <= ST_DONE;
                  cnt_clr    <= 1'b1;
                  user_reset <= 1'b0;
                  done       <= 1'b1;
               end else if (det_wrap) begin
                  state       <= ST_NEXT;
                  cnt_clr     <= 1'b1;
                  clk_en      <= 1'b0;
                  phy_nrst    <= 1'b0;
                  mmcm_rst_n  <= 1'b1;
                  logic_reset <= 1'b1;
                  user_reset  <= 1'b1;
               end
            end
            ST_CLK_EN: begin
               clk_en <= 1'b1;
               if (step_wrap && rdy[mode_idx]) begin
                  state    <= ST_PHY_REL;
                  cnt_clr  <= 1'b1;
                  phy_nrst <= 1'b1;
               end
            end
            ST_PHY_REL: begin
               if (step_wrap) begin
                  state      <= ST_MMCM_RST;
                  cnt_clr    <= 1'b1;
                  mmcm_rst_n <= 1'b0;
                  retry_cnt  <= retry_cnt + 2'd1;
               end
            end
            ST_MMCM_RST: begin
               if (step_wrap) begin
                  state      <= ST_MMCM_REL;
                  cnt_clr    <= 1'b1;
                  mmcm_rst_n <= 1'b1;
               end
            end
            ST_MMCM_REL: begin
               if (step_wrap) begin
                  state   <= ST_WAIT_LOCK;
                  cnt_clr <= 1'b1;
                  tries   <= '0;
               end
            end
            ST_WAIT_LOCK: begin
               if (step_wrap) begin
                  if (lock_s) begin
                     state       <= ST_LOGIC_H;
                     cnt_clr     <= 1'b1;
                     logic_reset <= 1'b1;
                  end else if (tries != TRY_LAST) begin
                     tries <= tries + 1'b1;
                  end else if (retry_cnt < MAXR) begin
                     state      <= ST_MMCM_RST;
                     cnt_clr    <= 1'b1;
                     mmcm_rst_n <= 1'b0;
                     retry_cnt  <= retry_cnt + 2'd1;
                  end else begin
                     state       <= ST_NEXT;
                     cnt_clr     <= 1'b1;
                     clk_en      <= 1'b0;
                     phy_nrst    <= 1'b0;
                     mmcm_rst_n  <= 1'b1;
                     logic_reset <= 1'b1;
                     user_reset  <= 1'b1;
                  end
               end
            end
            ST_LOGIC_H: begin
               if (step_wrap) begin
                  state       <= ST_LOGIC_L;
                  cnt_clr     <= 1'b1;
                  logic_reset <= 1'b0;
               end
            end
            ST_LOGIC_L: begin
               if (step_wrap) begin
                  state      <= ST_DONE;
                  cnt_clr    <= 1'b1;
                  user_reset <= 1'b0;
                  done       <= 1'b1;
               end
            end
            ST_DONE: begin
               if (loss) begin
                  user_reset <= 1'b1;
                  done       <= 1'b0;
                  if (RELOCK_EN) begin
                     cnt_clr <= 1'b1;
                     if (PMASK[mode_idx]) begin
                        state <= ST_DETECT;
                     end else begin
                        state      <= ST_MMCM_RST;
                        mmcm_rst_n <= 1'b0;
                        retry_cnt  <= 2'd1;
                     end
                  end
               end
            end
            ST_NEXT: begin
               cnt_clr <= 1'b1;
               // retry_cnt survives into FAIL for diagnosis
               if (mode_idx == LAST_IDX || FORCE_EN) begin
                  state       <= ST_FAIL;
                  fail        <= 1'b1;
                  clk_en      <= 1'b0;
                  mmcm_rst_n  <= 1'b0;
                  phy_nrst    <= 1'b0;
                  logic_reset <= 1'b1;
                  user_reset  <= 1'b1;
               end else begin
                  mode_idx  <= nxt_idx;
                  retry_cnt <= '0;
                  clk_en    <= ~PMASK[nxt_idx];
                  state     <= PMASK[nxt_idx] ?
                               ST_DETECT : ST_CLK_EN;
               end
            end
            ST_FAIL: begin
               fail <= 1'b1;
            end
            default: begin
               state <= ST_FAIL;
               fail  <= 1'b1;
            end
         endcase
      end
   end

endmodule
